// File: rtl/uart_phy_pkg.sv
// Shared state encoding and baud-divider helper for the 8N1 UART PHY.
package uart_phy_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // Clocks per oversample tick, truncated, never below one.
    function automatic int calcDiv(input int clkFreq, input int baud, input int oversample);
        int d;
        d = clkFreq / (baud * oversample);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_phy_tick_gen.sv
// Programmable divider emitting a one-cycle tick every DIV clocks; clear restarts the count.
module uart_tick_gen #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    output logic tick_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            cnt_q <= '0;
        end else if (cnt_q == CW'(DIV - 1)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick_o = (cnt_q == CW'(DIV - 1)) && !clear_i;

endmodule

// File: rtl/uart_phy.sv
// 8N1 UART serializer/deserializer: handshake-driven TX shifter and oversampling RX.
module uart_phy
    import uart_phy_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rxd,
    output logic       uart_txd,
    input  logic [7:0] data_in,
    input  logic       data_send,
    output logic       data_sent,
    output logic [7:0] data_out,
    output logic       data_received,
    output logic       frame_err
);

    localparam int DIV = calcDiv(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int SCW = $clog2(OVERSAMPLE);

    uart_state_e    txState_q;
    logic [7:0]     txShift_q;
    logic [SCW-1:0] txSample_q;
    logic [2:0]     txBit_q;
    logic           txTick;
    logic           txBitEnd;

    uart_state_e    rxState_q;
    logic [7:0]     rxShift_q;
    logic [SCW-1:0] rxSample_q;
    logic [2:0]     rxBit_q;
    logic [1:0]     rxSync_q;
    logic           rxPrev_q;
    logic           rxTick;
    logic           rxBitEnd;
    logic           rxd;

    // The TX divider is held clear while idle so every frame starts on a fresh tick boundary.
    uart_tick_gen #(.DIV(DIV)) txTickGen (
        .clk     (clk),
        .rst     (rst),
        .clear_i (txState_q == IDLE),
        .tick_o  (txTick)
    );

    uart_tick_gen #(.DIV(DIV)) rxTickGen (
        .clk     (clk),
        .rst     (rst),
        .clear_i (rxState_q == IDLE),
        .tick_o  (rxTick)
    );

    assign txBitEnd  = txTick && (txSample_q == SCW'(OVERSAMPLE - 1));
    assign rxBitEnd  = rxTick && (rxSample_q == SCW'(OVERSAMPLE - 1));
    assign rxd       = rxSync_q[1];
    assign data_sent = (txState_q == STOP) && txBitEnd;

    always_ff @(posedge clk) begin
        if (rst) begin
            txState_q  <= IDLE;
            txShift_q  <= '0;
            txSample_q <= '0;
            txBit_q    <= '0;
            uart_txd   <= 1'b1;
        end else begin
            if (txTick) begin
                txSample_q <= txBitEnd ? '0 : txSample_q + 1'b1;
            end
            case (txState_q)
                IDLE: begin
                    uart_txd <= 1'b1;
                    if (data_send) begin
                        txShift_q  <= data_in;
                        txSample_q <= '0;
                        txBit_q    <= '0;
                        uart_txd   <= 1'b0;
                        txState_q  <= START;
                    end
                end
                START: begin
                    if (txBitEnd) begin
                        uart_txd  <= txShift_q[0];
                        txState_q <= DATA;
                    end
                end
                DATA: begin
                    if (txBitEnd) begin
                        txShift_q <= txShift_q >> 1;
                        if (txBit_q == 3'(UART_DATA_BITS - 1)) begin
                            uart_txd  <= 1'b1;
                            txState_q <= STOP;
                        end else begin
                            txBit_q  <= txBit_q + 1'b1;
                            uart_txd <= txShift_q[1];
                        end
                    end
                end
                STOP: begin
                    if (txBitEnd) begin
                        txState_q <= IDLE;
                    end
                end
                default: txState_q <= IDLE;
            endcase
        end
    end

    // Start detection uses the previous synchronized level, so after a framing error
    // the line must return high before another falling edge can re-arm the receiver.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxState_q     <= IDLE;
            rxShift_q     <= '0;
            rxSample_q    <= '0;
            rxBit_q       <= '0;
            rxSync_q      <= 2'b11;
            rxPrev_q      <= 1'b1;
            data_out      <= '0;
            data_received <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            rxSync_q      <= {rxSync_q[0], uart_rxd};
            rxPrev_q      <= rxd;
            data_received <= 1'b0;
            frame_err     <= 1'b0;
            if (rxTick) begin
                rxSample_q <= rxSample_q + 1'b1;
            end
            case (rxState_q)
                IDLE: begin
                    if (rxPrev_q && !rxd) begin
                        rxSample_q <= '0;
                        rxBit_q    <= '0;
                        rxState_q  <= START;
                    end
                end
                START: begin
                    if (rxTick && (rxSample_q == SCW'(OVERSAMPLE / 2 - 1))) begin
                        rxSample_q <= '0;
                        rxState_q  <= rxd ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (rxBitEnd) begin
                        rxSample_q <= '0;
                        rxShift_q  <= {rxd, rxShift_q[7:1]};
                        if (rxBit_q == 3'(UART_DATA_BITS - 1)) begin
                            rxState_q <= STOP;
                        end else begin
                            rxBit_q <= rxBit_q + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (rxBitEnd) begin
                        if (rxd) begin
                            data_out      <= rxShift_q;
                            data_received <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        rxState_q <= IDLE;
                    end
                end
                default: rxState_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_phy.sv
// Self-checking bench for uart_phy: table of frames plus hand-built corner sequences.
module tb_uart_phy;

    localparam int BIT   = 16;
    localparam int FRAME = 10 * BIT;
    localparam int TXP   = 2;
    localparam int WIN   = 200;
    localparam int NVEC  = 14;

    typedef struct {
        logic       doTx;
        logic [7:0] txByte;
        logic       doRx;
        logic [7:0] rxByte;
        logic       rxStop;
        int         rxOff;
        logic       loopback;
        int         expSentCount;
        int         expRxGood;
        int         expRxErr;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       uartRxd;
    logic       uartTxd;
    logic [7:0] dataIn;
    logic       dataSend;
    logic       dataSent;
    logic [7:0] dataOut;
    logic       dataReceived;
    logic       frameErr;
    logic       loopback;
    logic       rxdDrive;
    logic [7:0] expLast;

    int checks;
    int failures;

    vec_t vecs[NVEC];

    uart_phy #(
        .CLK_FREQ   (1_600_000),
        .BAUD       (100_000),
        .OVERSAMPLE (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .uart_rxd      (uartRxd),
        .uart_txd      (uartTxd),
        .data_in       (dataIn),
        .data_send     (dataSend),
        .data_sent     (dataSent),
        .data_out      (dataOut),
        .data_received (dataReceived),
        .frame_err     (frameErr)
    );

    assign uartRxd = loopback ? uartTxd : rxdDrive;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line level at offset k clocks into an 8N1 frame; idle high outside the frame.
    function automatic logic frameLine(input logic [7:0] b, input logic stopBit, input int k);
        int bitIdx;
        if (k < 0 || k >= FRAME) return 1'b1;
        bitIdx = k / BIT;
        if (bitIdx == 0) return 1'b0;
        if (bitIdx <= 8) return b[bitIdx-1];
        return stopBit;
    endfunction

    function automatic vec_t mkVec(input logic doTx, input logic [7:0] txByte, input logic doRx,
                                   input logic [7:0] rxByte, input logic rxStop, input int rxOff,
                                   input logic lb);
        vec_t v;
        v.doTx         = doTx;
        v.txByte       = txByte;
        v.loopback     = lb;
        v.doRx         = doRx || lb;
        v.rxByte       = lb ? txByte : rxByte;
        v.rxStop       = lb ? 1'b1 : rxStop;
        v.rxOff        = lb ? TXP + 1 : rxOff;
        v.expSentCount = doTx ? 1 : 0;
        v.expRxGood    = (v.doRx && v.rxStop) ? 1 : 0;
        v.expRxErr     = (v.doRx && !v.rxStop) ? 1 : 0;
        return v;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Runs one window: optional TX request at TXP, optional RX frame at rxOff, then scores it.
    task automatic applyStimulus(input vec_t v, input string tag);
        int   txFirstBad = -1;
        int   sentCount = 0;
        int   sentCycle = -1;
        int   rxGood = 0;
        int   rxErr = 0;
        int   both = 0;
        int   evCycle = -1;
        int   evData = -1;
        int   inWin;
        logic expTx;
        loopback = v.loopback;
        for (int n = 0; n < WIN; n++) begin
            @(posedge clk);
            #1;
            expTx = v.doTx ? frameLine(v.txByte, 1'b1, n - (TXP + 1)) : 1'b1;
            if (uartTxd !== expTx && txFirstBad < 0) txFirstBad = n;
            if (dataSent) begin
                sentCount++;
                sentCycle = n;
            end
            if (dataReceived && frameErr) both++;
            if (dataReceived) begin
                rxGood++;
                evCycle = n;
                evData  = int'(dataOut);
            end
            if (frameErr) begin
                rxErr++;
                evCycle = n;
                evData  = int'(dataOut);
            end
            dataSend = v.doTx && (n == TXP);
            dataIn   = (v.doTx && n == TXP) ? v.txByte : 8'($urandom);
            rxdDrive = (v.doRx && !v.loopback) ? frameLine(v.rxByte, v.rxStop, n - v.rxOff) : 1'b1;
        end
        dataSend = 1'b0;
        rxdDrive = 1'b1;
        loopback = 1'b0;

        checkOutput({tag, "/txd_first_bad_cycle"}, txFirstBad, -1);
        checkOutput({tag, "/sent_count"}, sentCount, v.expSentCount);
        if (v.doTx) checkOutput({tag, "/sent_cycle"}, sentCycle, TXP + FRAME);
        checkOutput({tag, "/rx_good_count"}, rxGood, v.expRxGood);
        checkOutput({tag, "/rx_err_count"}, rxErr, v.expRxErr);
        checkOutput({tag, "/rx_both_high"}, both, 0);
        if (v.doRx) begin
            inWin = (evCycle >= v.rxOff + 9 * BIT && evCycle <= v.rxOff + FRAME + 4) ? 1 : 0;
            checkOutput({tag, "/rx_event_in_stop_bit"}, inWin, 1);
            if (v.rxStop) expLast = v.rxByte;
            checkOutput({tag, "/rx_event_data_out"}, evData, int'(expLast));
        end
        checkOutput({tag, "/data_out_hold"}, int'(dataOut), int'(expLast));
    endtask

    task automatic runBackToBack();
        int   sent[$];
        int   firstBad = -1;
        int   gap;
        logic expTx;
        for (int n = 0; n < 400; n++) begin
            @(posedge clk);
            #1;
            expTx = frameLine(8'h00, 1'b1, n - (TXP + 1)) & frameLine(8'hFF, 1'b1, n - (TXP + FRAME + 2));
            if (uartTxd !== expTx && firstBad < 0) firstBad = n;
            if (dataSent) sent.push_back(n);
            dataSend = (n >= TXP) && (sent.size() < 2);
            dataIn   = (sent.size() >= 1) ? 8'hFF : 8'h00;
        end
        dataSend = 1'b0;
        gap = (sent.size() == 2) ? sent[1] - sent[0] : -1;
        checkOutput("b2b/sent_count", sent.size(), 2);
        checkOutput("b2b/sent_gap", gap, FRAME + 1);
        checkOutput("b2b/txd_first_bad_cycle", firstBad, -1);
    endtask

    task automatic runGlitch();
        int events = 0;
        for (int n = 0; n < WIN; n++) begin
            @(posedge clk);
            #1;
            if (dataReceived || frameErr) events++;
            rxdDrive = !(n >= 5 && n < 9);
        end
        rxdDrive = 1'b1;
        checkOutput("glitch/rx_events", events, 0);
        checkOutput("glitch/data_out_hold", int'(dataOut), int'(expLast));
    endtask

    task automatic runResetMidFrame();
        int m = TXP + 1 + 50;
        int sentCount = 0;
        int firstBad = -1;
        for (int n = 0; n < WIN; n++) begin
            @(posedge clk);
            #1;
            if (n == m + 1) checkOutput("rstmid/txd_next_clk", int'(uartTxd), 1);
            if (n > m && uartTxd !== 1'b1 && firstBad < 0) firstBad = n;
            if (dataSent) sentCount++;
            dataSend = (n == TXP);
            dataIn   = 8'hC3;
            rst      = (n == m);
        end
        dataSend = 1'b0;
        rst      = 1'b0;
        expLast  = 8'h00;
        checkOutput("rstmid/sent_count", sentCount, 0);
        checkOutput("rstmid/txd_high_after", firstBad, -1);
        checkOutput("rstmid/data_out_cleared", int'(dataOut), 0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        dataIn   = 8'h00;
        dataSend = 1'b0;
        rxdDrive = 1'b1;
        loopback = 1'b0;
        expLast  = 8'h00;

        vecs[0] = mkVec(1'b1, 8'hA5, 1'b0, 8'h00, 1'b1, 0, 1'b0);
        vecs[1] = mkVec(1'b0, 8'h00, 1'b1, 8'h3C, 1'b1, 4, 1'b0);
        vecs[2] = mkVec(1'b0, 8'h00, 1'b1, 8'h55, 1'b0, 1, 1'b0);
        vecs[3] = mkVec(1'b1, 8'h81, 1'b1, 8'h7E, 1'b1, TXP + 1, 1'b0);
        vecs[4] = mkVec(1'b1, 8'h96, 1'b1, 8'h69, 1'b1, TXP + 5, 1'b0);
        for (int i = 5; i < NVEC; i++) begin
            vecs[i] = mkVec(1'($urandom_range(0, 1)), 8'($urandom), 1'b1, 8'($urandom),
                            1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 12)), 1'b0);
        end

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset/txd", int'(uartTxd), 1);
        checkOutput("reset/data_sent", int'(dataSent), 0);
        checkOutput("reset/data_received", int'(dataReceived), 0);
        checkOutput("reset/frame_err", int'(frameErr), 0);
        checkOutput("reset/data_out", int'(dataOut), 0);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        runBackToBack();
        applyStimulus(mkVec(1'b1, 8'h3C, 1'b0, 8'h00, 1'b1, 0, 1'b1), "loopback");
        runGlitch();
        applyStimulus(mkVec(1'b0, 8'h00, 1'b1, 8'h55, 1'b0, 3, 1'b0), "framing");
        checkOutput("framing/data_out_still_3c", int'(dataOut), 8'h3C);
        runResetMidFrame();
        applyStimulus(mkVec(1'b1, 8'h5A, 1'b0, 8'h00, 1'b1, 0, 1'b0), "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
